// File: rtl/can_pkg.sv
// Shared types for the CAN acceptance-filter bank: ID width, table entry layout
// and the scan controller state encoding.
package can_pkg;

    localparam int CAN_ID_W = 11;

    typedef logic [CAN_ID_W-1:0] can_id_t;

    typedef struct packed {
        logic    en;
        can_id_t code;
        can_id_t mask;
    } filt_entry_t;

    typedef enum logic {
        IDLE,
        SCAN
    } fbank_state_t;

endpackage

// File: rtl/can_filter_match.sv
// Single-entry acceptance compare: an ID hits when the entry is enabled and every
// bit selected by the mask equals the corresponding code bit.
module can_filter_match
    import can_pkg::*;
(
    input  can_id_t     id,
    input  filt_entry_t entry,
    output logic        hit
);

    assign hit = entry.en && (((id ^ entry.code) & entry.mask) == '0);

endmodule

// File: rtl/can_filter_bank.sv
// Time-shared CAN acceptance filter: one comparator walks the code/mask table one
// entry per cycle and reports the lowest-numbered matching entry, or a drop.
module can_filter_bank
    import can_pkg::*;
#(
    parameter  int NUM_FILTERS = 8,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = $clog2(NUM_FILTERS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [10:0]      cfg_code,
    input  logic [10:0]      cfg_mask,
    input  logic [10:0]      id_in,
    input  logic             id_valid_in,
    output logic             id_ready_out,
    output logic             id_valid_out,
    output logic [10:0]      id_out,
    output logic [IDX_W-1:0] hit_idx,
    output logic             id_drop,
    output logic [CNT_W-1:0] drop_count
);

    fbank_state_t     state_q, state_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    can_id_t          id_q, id_d;
    can_id_t          id_out_q, id_out_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             id_valid_out_q, id_valid_out_d;
    logic             id_drop_q, id_drop_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    filt_entry_t      filt_q [NUM_FILTERS];
    filt_entry_t      filt_d [NUM_FILTERS];

    logic cfg_in_range;
    logic last_entry;
    logic hit;

    // The table is read live, so a write landing ahead of scan_idx affects this frame.
    can_filter_match u_match (
        .id    (id_q),
        .entry (filt_q[scan_idx_q]),
        .hit   (hit)
    );

    assign cfg_in_range = ({1'b0, cfg_idx} < (IDX_W+1)'(NUM_FILTERS));
    assign last_entry   = (scan_idx_q == IDX_W'(NUM_FILTERS - 1));

    // NOTE: rst_n gates ready so upstream never sees a handshake while held in reset.
    assign id_ready_out = rst_n && (state_q == IDLE);

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no latches are inferred.
        state_d        = state_q;
        scan_idx_d     = scan_idx_q;
        id_d           = id_q;
        id_out_d       = id_out_q;
        hit_idx_d      = hit_idx_q;
        id_valid_out_d = 1'b0;
        id_drop_d      = 1'b0;
        drop_count_d   = drop_count_q;
        filt_d         = filt_q;

        if (cfg_we && cfg_in_range) begin
            filt_d[cfg_idx] = '{en: cfg_en, code: cfg_code, mask: cfg_mask};
        end

        case (state_q)
            IDLE: begin
                if (id_valid_in) begin
                    id_d       = id_in;
                    scan_idx_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    id_out_d       = id_q;
                    hit_idx_d      = scan_idx_q;
                    id_valid_out_d = 1'b1;
                    state_d        = IDLE;
                end else if (last_entry) begin
                    id_drop_d = 1'b1;
                    if (drop_count_q != {CNT_W{1'b1}}) begin
                        drop_count_d = drop_count_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the filter table is reset too, because reset must leave every entry disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            scan_idx_q     <= '0;
            id_q           <= '0;
            id_out_q       <= '0;
            hit_idx_q      <= '0;
            id_valid_out_q <= 1'b0;
            id_drop_q      <= 1'b0;
            drop_count_q   <= '0;
            foreach (filt_q[i]) filt_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            id_q           <= id_d;
            id_out_q       <= id_out_d;
            hit_idx_q      <= hit_idx_d;
            id_valid_out_q <= id_valid_out_d;
            id_drop_q      <= id_drop_d;
            drop_count_q   <= drop_count_d;
            filt_q         <= filt_d;
        end
    end

    assign id_valid_out = id_valid_out_q;
    assign id_out       = id_out_q;
    assign hit_idx      = hit_idx_q;
    assign id_drop      = id_drop_q;
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_can_filter_bank.sv
// Self-checking bench for can_filter_bank: directed scenarios followed by random
// frames, all predicted by a first-match table model kept in the bench.
module tb_can_filter_bank;

    localparam int N    = 8;
    localparam int IW   = $clog2(N);
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic          cfg_en;
    logic [10:0]   cfg_code;
    logic [10:0]   cfg_mask;
    logic [10:0]   id_in;
    logic          id_valid_in;
    logic          id_ready_out;
    logic          id_valid_out;
    logic [10:0]   id_out;
    logic [IW-1:0] hit_idx;
    logic          id_drop;
    logic [CW-1:0] drop_count;

    can_filter_bank #(.NUM_FILTERS(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_en       (cfg_en),
        .cfg_code     (cfg_code),
        .cfg_mask     (cfg_mask),
        .id_in        (id_in),
        .id_valid_in  (id_valid_in),
        .id_ready_out (id_ready_out),
        .id_valid_out (id_valid_out),
        .id_out       (id_out),
        .hit_idx      (hit_idx),
        .id_drop      (id_drop),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the table as plain arrays plus a running drop tally.
    bit          m_en   [N];
    logic [10:0] m_code [N];
    logic [10:0] m_mask [N];
    int          m_drops;

    logic [10:0] b2b_ids [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_match(input logic [10:0] id);
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && (((id ^ m_code[i]) & m_mask[i]) == 11'h000)) return i;
        end
        return -1;
    endfunction

    function automatic int model_count();
        return (m_drops > CMAX) ? CMAX : m_drops;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_en[i]   = 1'b0;
            m_code[i] = '0;
            m_mask[i] = '0;
        end
        m_drops = 0;
    endtask

    task automatic cfg_write(input int idx, input bit en, input logic [10:0] code,
                             input logic [10:0] mask);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(idx);
        cfg_en   = en;
        cfg_code = code;
        cfg_mask = mask;
        @(negedge clk);
        cfg_we = 1'b0;
        if (idx < N) begin
            m_en[idx]   = en;
            m_code[idx] = code;
            m_mask[idx] = mask;
        end
    endtask

    // Presents one ID and returns just after the accept edge.
    task automatic start_frame(input logic [10:0] id);
        @(negedge clk);
        check("ready_idle", 32'(id_ready_out), 32'd1);
        id_in       = id;
        id_valid_in = 1'b1;
        @(posedge clk);
        #1;
        id_valid_in = 1'b0;
        check("ready_scan", 32'(id_ready_out), 32'd0);
    endtask

    // Counts edges until a result pulse appears, bounded by a cycle budget.
    task automatic collect(input int lat0, output int lat);
        lat = lat0;
        while (lat < N + 3) begin
            @(posedge clk);
            #1;
            lat++;
            if (id_valid_out || id_drop) break;
        end
        check("pulse_seen", 32'(id_valid_out | id_drop), 32'd1);
        check("not_both", 32'(id_valid_out & id_drop), 32'd0);
    endtask

    task automatic finish_frame(input logic [10:0] id, input int lat, input int exp_idx);
        int exp_lat;
        exp_lat = (exp_idx >= 0) ? exp_idx + 1 : N;
        if (exp_idx < 0) m_drops++;
        check("latency", 32'(lat), 32'(exp_lat));
        check("valid_out", 32'(id_valid_out), 32'(exp_idx >= 0));
        check("drop", 32'(id_drop), 32'(exp_idx < 0));
        if (exp_idx >= 0) begin
            check("id_out", 32'(id_out), 32'(id));
            check("hit_idx", 32'(hit_idx), 32'(exp_idx));
        end
        check("drop_count", 32'(drop_count), 32'(model_count()));
        check("ready_in_pulse", 32'(id_ready_out), 32'd1);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", 32'(id_valid_out | id_drop), 32'd0);
    endtask

    task automatic run_frame(input logic [10:0] id);
        int exp_idx;
        int lat;
        exp_idx = model_match(id);
        start_frame(id);
        collect(0, lat);
        finish_frame(id, lat, exp_idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          pick;
        logic [10:0] rid;

        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_en      = 1'b0;
        cfg_code    = '0;
        cfg_mask    = '0;
        id_in       = '0;
        id_valid_in = 1'b0;
        model_clear();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(id_ready_out), 32'd0);
        check("rst_valid", 32'(id_valid_out), 32'd0);
        check("rst_id_out", 32'(id_out), 32'd0);
        check("rst_hit_idx", 32'(hit_idx), 32'd0);
        check("rst_drop", 32'(id_drop), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;

        // Empty table rejects everything after a full scan.
        run_frame(11'h100);

        // Single exact-match entry.
        cfg_write(3, 1'b1, 11'h100, 11'h7FF);
        run_frame(11'h100);
        run_frame(11'h101);

        // Lowest index wins.
        cfg_write(1, 1'b1, 11'h300, 11'h700);
        cfg_write(5, 1'b1, 11'h310, 11'h7FF);
        run_frame(11'h310);
        run_frame(11'h200);

        // Accept-all entry with back-to-back frames held valid.
        cfg_write(0, 1'b1, 11'h000, 11'h000);
        b2b_ids[0] = 11'h123;
        b2b_ids[1] = 11'h456;
        b2b_ids[2] = 11'h7FF;
        @(negedge clk);
        id_in       = b2b_ids[0];
        id_valid_in = 1'b1;
        for (int f = 0; f < 3; f++) begin
            @(posedge clk);
            #1;
            check("b2b_ready_low", 32'(id_ready_out), 32'd0);
            if (f < 2) id_in = b2b_ids[f+1];
            else id_valid_in = 1'b0;
            @(posedge clk);
            #1;
            check("b2b_valid", 32'(id_valid_out), 32'd1);
            check("b2b_id_out", 32'(id_out), 32'(b2b_ids[f]));
            check("b2b_hit_idx", 32'(hit_idx), 32'd0);
            check("b2b_ready_back", 32'(id_ready_out), 32'd1);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            check("b2b_no_extra", 32'(id_valid_out | id_drop), 32'd0);
        end
        cfg_write(0, 1'b0, 11'h000, 11'h000);

        // Disabled entry, then enabled by a write while scan_idx is 1.
        cfg_write(2, 1'b0, 11'h2AA, 11'h7FF);
        run_frame(11'h2AA);
        start_frame(11'h2AA);
        @(posedge clk);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = IW'(2);
        cfg_en   = 1'b1;
        cfg_code = 11'h2AA;
        cfg_mask = 11'h7FF;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        m_en[2] = 1'b1;
        check("live_no_early", 32'(id_valid_out | id_drop), 32'd0);
        collect(2, lat);
        finish_frame(11'h2AA, lat, 2);

        // Reset in the middle of a scan.
        start_frame(11'h555);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(id_ready_out), 32'd0);
        check("midrst_count", 32'(drop_count), 32'd0);
        repeat (N) begin
            @(negedge clk);
            check("midrst_no_pulse", 32'(id_valid_out | id_drop), 32'd0);
            check("midrst_ready_low", 32'(id_ready_out), 32'd0);
        end
        rst_n = 1'b1;
        model_clear();
        repeat (3) begin
            @(posedge clk);
            #1;
            check("postrst_quiet", 32'(id_valid_out | id_drop), 32'd0);
        end
        run_frame(11'h100);

        // Random table contents and IDs against the model.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(2) == 0) begin
                cfg_write(int'($urandom_range(N - 1)), 1'($urandom_range(3) != 0),
                          11'($urandom), 11'($urandom | $urandom));
            end
            pick = int'($urandom_range(N - 1));
            if ($urandom_range(1) == 0)
                rid = (m_code[pick] & m_mask[pick]) | (11'($urandom) & ~m_mask[pick]);
            else
                rid = 11'($urandom);
            run_frame(rid);
        end

        // Drive the drop counter into saturation.
        for (int i = 0; i < N; i++) cfg_write(i, 1'b0, 11'($urandom), 11'($urandom));
        for (int t = 0; t < CMAX + 3; t++) run_frame(11'($urandom));
        check("drop_count_saturated", 32'(drop_count), 32'(CMAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
